// File: rtl/regfile_wb_ctrl.sv
// Write-side controller for the register file. It arbitrates ALU and LSU results onto the single
// write port and keeps a busy-bit scoreboard of destinations that are still in flight.
module regfile_wb_ctrl #(
   parameter int WIDTH = 32,
   parameter int NREG  = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             iss_valid,
   input  logic [4:0]       iss_rd,
   output logic             iss_ready,
   input  logic             alu_valid,
   input  logic [4:0]       alu_rd,
   input  logic [WIDTH-1:0] alu_data,
   output logic             alu_ready,
   input  logic             lsu_valid,
   input  logic [4:0]       lsu_rd,
   input  logic [WIDTH-1:0] lsu_data,
   output logic             lsu_ready,
   output logic             rf_wr,
   output logic [4:0]       rf_c_idx,
   output logic [WIDTH-1:0] rf_c,
   input  logic [4:0]       rs1_idx,
   input  logic [4:0]       rs2_idx,
   output logic             rs1_busy,
   output logic             rs2_busy,
   output logic             rs1_fwd,
   output logic             rs2_fwd,
   output logic             err_spur
);

   typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_t;

   src_t             rr_last;
   logic [NREG-1:0]  busy;
   logic [NREG-1:0]  busy_nxt;
   logic             iss_fire;
   logic             tie_p0;
   logic             grant_alu_p0;
   logic             grant_lsu_p0;
   logic             grant_p0;
   logic [4:0]       sel_rd_p0;
   logic [WIDTH-1:0] sel_data_p0;

   // busy[0] is never set, so rd=0 always reads as ready.
   assign iss_ready = ~busy[iss_rd];
   assign iss_fire  = iss_valid & iss_ready & (iss_rd != 5'd0);

   // On a tie, grant whichever source lost the previous tie.
   assign tie_p0       = alu_valid & lsu_valid;
   assign grant_lsu_p0 = lsu_valid & (~alu_valid | (rr_last == SRC_ALU));
   assign grant_alu_p0 = alu_valid & ~grant_lsu_p0;
   assign grant_p0     = grant_alu_p0 | grant_lsu_p0;
   assign sel_rd_p0    = grant_lsu_p0 ? lsu_rd : alu_rd;
   assign sel_data_p0  = grant_lsu_p0 ? lsu_data : alu_data;
   assign alu_ready    = grant_alu_p0;
   assign lsu_ready    = grant_lsu_p0;

   // The clear commits on the same edge as the regfile write. A same-rd issue can't collide with it
   // because iss_ready is still low while that rd is busy.
   always_comb begin
      busy_nxt = busy;
      if (rf_wr)
         busy_nxt[rf_c_idx] = 1'b0;
      if (iss_fire)
         busy_nxt[iss_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // ---- p0 -> p1: registered write port ----
   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy     <= '0;
         rf_wr    <= 1'b0;
         rf_c_idx <= 5'd0;
         rf_c     <= '0;
         err_spur <= 1'b0;
         rr_last  <= SRC_ALU;
      end else begin
         busy  <= busy_nxt;
         rf_wr <= grant_p0 & (sel_rd_p0 != 5'd0);
         if (grant_p0) begin
            rf_c_idx <= sel_rd_p0;
            rf_c     <= sel_data_p0;
         end
         if (tie_p0)
            rr_last <= grant_lsu_p0 ? SRC_LSU : SRC_ALU;
         if (grant_p0 && (sel_rd_p0 != 5'd0) && !busy[sel_rd_p0])
            err_spur <= 1'b1;
      end
   end

   assign rs1_fwd  = rf_wr & (rf_c_idx == rs1_idx) & (rs1_idx != 5'd0);
   assign rs2_fwd  = rf_wr & (rf_c_idx == rs2_idx) & (rs2_idx != 5'd0);
   assign rs1_busy = busy[rs1_idx] & ~rs1_fwd;
   assign rs2_busy = busy[rs2_idx] & ~rs2_fwd;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: directed stimulus queues the writes it expects, and a
// monitor checks every rf_wr cycle against that queue.
module tb_regfile_wb_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        lsu_ready;
   logic        rf_wr;
   logic [4:0]  rf_c_idx;
   logic [31:0] rf_c;
   logic [4:0]  rs1_idx;
   logic [4:0]  rs2_idx;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        rs1_fwd;
   logic        rs2_fwd;
   logic        err_spur;

   int nchk = 0;
   int nerr = 0;
   logic [36:0] exp_q[$];

   regfile_wb_ctrl #(.WIDTH(32), .NREG(32)) dut (
      .clk(clk), .rstn(rstn),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .rf_wr(rf_wr), .rf_c_idx(rf_c_idx), .rf_c(rf_c),
      .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
      .err_spur(err_spur)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] data);
      exp_q.push_back({rd, data});
   endtask

   // Monitor: every write-port cycle must match the oldest queued expectation.
   always @(posedge clk) begin
      logic [36:0] e;
      #1;
      if (rf_wr === 1'b1) begin
         nchk++;
         if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL wr_unexpected: got idx=%0d data=%h expected no write", rf_c_idx, rf_c);
         end else begin
            e = exp_q.pop_front();
            chk("wr_idx", 32'(rf_c_idx), 32'(e[36:32]));
            chk("wr_data", rf_c, e[31:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd5;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1111_1111;
      lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h2222_2222;
      rs1_idx = 5'd5; rs2_idx = 5'd6;
      step(); step();
      chk("rst_rf_wr", 32'(rf_wr), 32'd0);
      chk("rst_err", 32'(err_spur), 32'd0);
      chk("rst_busy5", 32'(rs1_busy), 32'd0);
      chk("rst_busy6", 32'(rs2_busy), 32'd0);
      chk("rst_idx", 32'(rf_c_idx), 32'd0);
      chk("rst_c", rf_c, 32'd0);
      iss_valid = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
      step();
      rstn = 1'b1;
      step();

      // Issue rd=5, then ALU result, then forwarding, then clear.
      iss_valid = 1'b1; iss_rd = 5'd5; #1;
      chk("iss5_ready", 32'(iss_ready), 32'd1);
      step();
      iss_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF; rs1_idx = 5'd5; #1;
      chk("alu5_ready", 32'(alu_ready), 32'd1);
      chk("busy5_set", 32'(rs1_busy), 32'd1);
      push(5'd5, 32'hDEAD_BEEF);
      step();
      alu_valid = 1'b0; #1;
      chk("fwd5", 32'(rs1_fwd), 32'd1);
      chk("fwd5_busy", 32'(rs1_busy), 32'd0);
      step();
      chk("busy5_clr", 32'(rs1_busy), 32'd0);
      chk("nofwd5", 32'(rs1_fwd), 32'd0);

      // Tie between ALU(3) and LSU(4): LSU first, then ALU.
      iss_valid = 1'b1; iss_rd = 5'd3; step();
      iss_rd = 5'd4; step();
      iss_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_3333;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h4444_4444; #1;
      chk("tie1_lsu", 32'(lsu_ready), 32'd1);
      chk("tie1_alu", 32'(alu_ready), 32'd0);
      push(5'd4, 32'h4444_4444);
      step();
      chk("tie2_alu", 32'(alu_ready), 32'd1);
      chk("tie2_lsu", 32'(lsu_ready), 32'd0);
      push(5'd3, 32'h3333_3333);
      step();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      rs1_idx = 5'd3; rs2_idx = 5'd4;
      step();
      chk("busy3_clr", 32'(rs1_busy), 32'd0);
      chk("busy4_clr", 32'(rs2_busy), 32'd0);

      // Re-issue of a busy rd is held off until the cycle after the clear.
      iss_valid = 1'b1; iss_rd = 5'd7; step();
      #1;
      chk("iss7_busy", 32'(iss_ready), 32'd0);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_0007; #1;
      chk("alu7_ready", 32'(alu_ready), 32'd1);
      push(5'd7, 32'h7777_0007);
      step();
      alu_valid = 1'b0; #1;
      chk("iss7_clrcyc", 32'(iss_ready), 32'd0);
      step();
      chk("iss7_after", 32'(iss_ready), 32'd1);
      step();
      iss_valid = 1'b0; rs1_idx = 5'd7; #1;
      chk("busy7_reset", 32'(rs1_busy), 32'd1);

      // rd=0: always ready, no write, no error.
      iss_valid = 1'b1; iss_rd = 5'd0; #1;
      chk("iss0_ready", 32'(iss_ready), 32'd1);
      step();
      iss_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_0001; #1;
      chk("alu0_ready", 32'(alu_ready), 32'd1);
      step();
      alu_valid = 1'b0; rs2_idx = 5'd0; #1;
      chk("rd0_nowr", 32'(rf_wr), 32'd0);
      chk("rd0_busy", 32'(rs2_busy), 32'd0);
      chk("rd0_err", 32'(err_spur), 32'd0);
      chk("busy7_kept", 32'(rs1_busy), 32'd1);

      // Spurious LSU write to non-busy rd=9.
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9999_0009; #1;
      chk("lsu9_ready", 32'(lsu_ready), 32'd1);
      push(5'd9, 32'h9999_0009);
      step();
      lsu_valid = 1'b0; #1;
      chk("err_set", 32'(err_spur), 32'd1);
      step(); step();
      chk("err_sticky", 32'(err_spur), 32'd1);
      rstn = 1'b0;
      step();
      chk("err_rst", 32'(err_spur), 32'd0);
      chk("rst2_busy7", 32'(rs1_busy), 32'd0);
      chk("rst2_wr", 32'(rf_wr), 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
